// File: rtl/uart_rx_frame_ctrl_if.sv
// Link between the UART RX frame controller, its edge/bit counter and the
// RX-side consumer of received words and error pulses.
interface uart_rx_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 5
);
  logic                      cnt_enable;
  logic [PRESCALE_WIDTH-1:0] edge_count;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      data_valid;
  logic                      parity_error;
  logic                      stop_error;
  logic                      start_glitch;

  modport master (
    input  edge_count,
    output cnt_enable,
    output P_DATA,
    output data_valid,
    output parity_error,
    output stop_error,
    output start_glitch
  );

  modport slave (
    output edge_count,
    input  cnt_enable,
    input  P_DATA,
    input  data_valid,
    input  parity_error,
    input  stop_error,
    input  start_glitch
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, 3-sample majority voting,
// LSB-first deserialisation, optional parity and stop-bit checking.
module uart_rx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  uart_rx_frame_ctrl_if.master      rx_if
);

  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                    state_q;
  logic                      cnt_enable_q;
  logic                      s0_q, s1_q, s2_q;
  logic [DATA_WIDTH-1:0]     shift_q;
  logic [DATA_WIDTH-1:0]     p_data_q;
  logic [IdxW-1:0]           idx_q;
  logic                      par_en_q, par_type_q, par_err_q;
  logic                      data_valid_q, parity_error_q, stop_error_q, start_glitch_q;

  logic [PRESCALE_WIDTH-1:0] mid, mid_m1, mid_p1;
  logic                      bit_end, bit_val;

  assign mid     = prescale >> 1;
  assign mid_m1  = mid - PRESCALE_WIDTH'(1);
  assign mid_p1  = mid + PRESCALE_WIDTH'(1);
  assign bit_end = (rx_if.edge_count == prescale);
  assign bit_val = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= StIdle;
      cnt_enable_q   <= 1'b0;
      s0_q           <= 1'b0;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      shift_q        <= '0;
      p_data_q       <= '0;
      idx_q          <= '0;
      par_en_q       <= 1'b0;
      par_type_q     <= 1'b0;
      par_err_q      <= 1'b0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      start_glitch_q <= 1'b0;
    end else begin
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      start_glitch_q <= 1'b0;

      // The last sample lands at mid+1 < prescale, so it is settled at bit end.
      if (cnt_enable_q) begin
        if (rx_if.edge_count == mid_m1) s0_q <= RX_IN;
        if (rx_if.edge_count == mid)    s1_q <= RX_IN;
        if (rx_if.edge_count == mid_p1) s2_q <= RX_IN;
      end

      case (state_q)
        StIdle: begin
          if (!RX_IN) begin
            state_q      <= StStart;
            cnt_enable_q <= 1'b1;
          end
        end
        StStart: begin
          if (bit_end) begin
            if (bit_val) begin
              start_glitch_q <= 1'b1;
              cnt_enable_q   <= 1'b0;
              state_q        <= StIdle;
            end else begin
              idx_q      <= '0;
              par_en_q   <= parity_enable;
              par_type_q <= parity_type;
              par_err_q  <= 1'b0;
              state_q    <= StData;
            end
          end
        end
        StData: begin
          if (bit_end) begin
            shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
            if (idx_q == IdxW'(DATA_WIDTH - 1)) begin
              state_q <= par_en_q ? StParity : StStop;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            par_err_q <= bit_val != ((^shift_q) ^ par_type_q);
            state_q   <= StStop;
          end
        end
        StStop: begin
          if (bit_end) begin
            state_q      <= StIdle;
            cnt_enable_q <= 1'b0;
            if (!bit_val)  stop_error_q   <= 1'b1;
            if (par_err_q) parity_error_q <= 1'b1;
            if (bit_val && !par_err_q) begin
              p_data_q     <= shift_q;
              data_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= StIdle;
          cnt_enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.cnt_enable   = cnt_enable_q;
  assign rx_if.P_DATA       = p_data_q;
  assign rx_if.data_valid   = data_valid_q;
  assign rx_if.parity_error = parity_error_q;
  assign rx_if.stop_error   = stop_error_q;
  assign rx_if.start_glitch = start_glitch_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed, table-driven bench for uart_rx_frame_ctrl with a behavioural
// model of the upstream edge counter.
module tb_uart_rx_frame_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [4:0] prescale = 5'd8;
  logic       parity_enable = 1'b0;
  logic       parity_type = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_perr = 0, n_serr = 0, n_glitch = 0, n_cnt = 0;
  logic [7:0] got_q[$];

  uart_rx_frame_ctrl_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) bus ();

  uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_IN         (RX_IN),
    .prescale      (prescale),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .rx_if         (bus)
  );

  always #5 CLK = ~CLK;

  // Edge counter: held at 1 while disabled, counts 1..prescale when enabled.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                             bus.edge_count <= 5'd1;
    else if (!bus.cnt_enable)             bus.edge_count <= 5'd1;
    else if (bus.edge_count == prescale)  bus.edge_count <= 5'd1;
    else                                  bus.edge_count <= bus.edge_count + 5'd1;
  end

  always @(negedge CLK) begin
    if (bus.data_valid) begin
      n_valid++;
      got_q.push_back(bus.P_DATA);
      checks++;
      if (bus.parity_error || bus.stop_error || bus.start_glitch) begin
        errors++;
        $display("FAIL valid_excl: error pulse alongside data_valid pe=%0b se=%0b sg=%0b",
                 bus.parity_error, bus.stop_error, bus.start_glitch);
      end
    end
    if (bus.parity_error) n_perr++;
    if (bus.stop_error)   n_serr++;
    if (bus.start_glitch) n_glitch++;
    if (bus.cnt_enable)   n_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_valid = 0; n_perr = 0; n_serr = 0; n_glitch = 0; n_cnt = 0;
    got_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  // Drives start, LSB-first data, optional parity and stop bit; samples at
  // positions set in mask are inverted within bit number invb.
  task automatic send_frame(input logic [7:0] d, input logic pon, input logic pb,
                            input logic sb, input int invb, input logic [31:0] mask,
                            input int limit);
    logic bits[$];
    logic val;
    int   n;
    n = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pon) bits.push_back(pb);
    bits.push_back(sb);
    for (int b = 0; b < bits.size(); b++) begin
      for (int p = 0; p < int'(prescale); p++) begin
        if (n >= limit) return;
        val = bits[b];
        if (b == invb && mask[p]) val = ~val;
        @(negedge CLK);
        RX_IN = val;
        n++;
      end
    end
  endtask

  typedef struct {
    int         ps;
    logic       pe;
    logic       pt;
    logic [7:0] data;
    logic       pb;
    logic       sb;
    int         invb;
    logic [31:0] mask;
    int         ev;
    int         eperr;
    int         eserr;
    logic [7:0] epd;
    int         ecnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 32'h0,       1, 0, 0, 8'hA5, 80};
    vecs[1]  = '{8,  1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 32'h0,       1, 0, 0, 8'h3C, 88};
    vecs[2]  = '{8,  1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, -1, 32'h0,       0, 1, 0, 8'h3C, 88};
    vecs[3]  = '{8,  1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, -1, 32'h0,       1, 0, 0, 8'h3C, 88};
    vecs[4]  = '{8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, -1, 32'h0,       0, 0, 1, 8'h3C, 80};
    vecs[5]  = '{8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, -1, 32'h0,       1, 0, 0, 8'h5A, 80};
    vecs[6]  = '{8,  1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, -1, 32'h0,       0, 1, 1, 8'h5A, 88};
    vecs[7]  = '{16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 2,  32'h0000100, 1, 0, 0, 8'h55, 160};
    vecs[8]  = '{16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 2,  32'h0000180, 1, 0, 0, 8'h57, 160};
    vecs[9]  = '{16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 2,  32'h0000300, 1, 0, 0, 8'h57, 160};
    vecs[10] = '{4,  1'b1, 1'b1, 8'h81, 1'b1, 1'b1, -1, 32'h0,       1, 0, 0, 8'h81, 44};
    vecs[11] = '{30, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, -1, 32'h0,       1, 0, 0, 8'hC3, 300};

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset_outputs",
          {27'd0, bus.cnt_enable, bus.data_valid, bus.parity_error, bus.stop_error,
           bus.start_glitch}, 32'd0);
    check("reset_pdata", {24'd0, bus.P_DATA}, 32'd0);
    RST = 1'b1;
    idle(4);

    for (int i = 0; i < 12; i++) begin
      prescale      = 5'(vecs[i].ps);
      parity_enable = vecs[i].pe;
      parity_type   = vecs[i].pt;
      idle(2);
      clear_counts();
      send_frame(vecs[i].data, vecs[i].pe, vecs[i].pb, vecs[i].sb, vecs[i].invb,
                 vecs[i].mask, 1000);
      idle(4);
      check($sformatf("v%0d valid", i),  n_valid,  vecs[i].ev);
      check($sformatf("v%0d perr", i),   n_perr,   vecs[i].eperr);
      check($sformatf("v%0d serr", i),   n_serr,   vecs[i].eserr);
      check($sformatf("v%0d glitch", i), n_glitch, 0);
      check($sformatf("v%0d pdata", i),  {24'd0, bus.P_DATA}, {24'd0, vecs[i].epd});
      check($sformatf("v%0d cnt_cyc", i), n_cnt,   vecs[i].ecnt);
    end

    // Short low pulse: rejected start bit
    prescale = 5'd8; parity_enable = 1'b0; parity_type = 1'b0;
    idle(2);
    clear_counts();
    @(negedge CLK); RX_IN = 1'b0;
    @(negedge CLK); RX_IN = 1'b0;
    idle(14);
    check("glitch_pulse",  n_glitch, 1);
    check("glitch_valid",  n_valid,  0);
    check("glitch_errs",   n_perr + n_serr, 0);
    check("glitch_cnt_cyc", n_cnt,   8);
    check("glitch_cnt_en", {31'd0, bus.cnt_enable}, 0);
    check("glitch_pdata",  {24'd0, bus.P_DATA}, 32'hC3);

    // Parity settings changed mid-frame are ignored
    clear_counts();
    fork
      send_frame(8'h0F, 1'b0, 1'b0, 1'b1, -1, 32'h0, 1000);
      begin
        repeat (20) @(negedge CLK);
        parity_enable = 1'b1;
        parity_type   = 1'b1;
      end
    join
    idle(4);
    check("midcfg_valid",  n_valid, 1);
    check("midcfg_perr",   n_perr,  0);
    check("midcfg_pdata",  {24'd0, bus.P_DATA}, 32'h0F);
    check("midcfg_cnt",    n_cnt,   80);
    parity_enable = 1'b0; parity_type = 1'b0;
    idle(4);

    // Reset asserted during DATA
    clear_counts();
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, -1, 32'h0, 40);
    #2 RST = 1'b0;
    #1;
    check("midrst_outputs",
          {27'd0, bus.cnt_enable, bus.data_valid, bus.parity_error, bus.stop_error,
           bus.start_glitch}, 32'd0);
    check("midrst_pdata", {24'd0, bus.P_DATA}, 32'd0);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle(4);
    check("midrst_no_pulses", n_valid + n_perr + n_serr + n_glitch, 0);
    clear_counts();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1, 32'h0, 1000);
    idle(4);
    check("after_rst_valid", n_valid, 1);
    check("after_rst_pdata", {24'd0, bus.P_DATA}, 32'hFF);

    // Back-to-back frames, one idle cycle apart
    clear_counts();
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1, 32'h0, 1000);
    idle(1);
    send_frame(8'hE7, 1'b0, 1'b0, 1'b1, -1, 32'h0, 1000);
    idle(4);
    check("b2b_valid", n_valid, 2);
    check("b2b_errs",  n_perr + n_serr + n_glitch, 0);
    check("b2b_first",  (got_q.size() > 0) ? {24'd0, got_q[0]} : 32'hFFFF_FFFF, 32'h12);
    check("b2b_second", (got_q.size() > 1) ? {24'd0, got_q[1]} : 32'hFFFF_FFFF, 32'hE7);
    check("b2b_pdata", {24'd0, bus.P_DATA}, 32'hE7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
